conv_encoder_k7: RTL

- Rate-1/2, constraint-length-7 convolutional encoder with valid/ready handshakes on both sides; the transmit-side counterpart of the 64-state Viterbi decoder.
- Consumes one information bit per accepted input beat and emits one 2-bit code pair per output beat.
- Pair bit ordering matches the decoder's rx_pair and branch-metric convention.
- Optionally appends K-1 zero tail bits per frame so each frame ends in state 0, the decoder's traceback start state.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_enc_core.sv | 26 ++
 rtl/conv_encoder_k7.sv | 83 ++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, state type and parity helper for the K=7 rate-1/2 code
package conv_pkg;
  localparam int K = 7;
  localparam int M = K - 1;

  // Bit K-1 of each polynomial taps the current input bit.
  localparam logic [K-1:0] G0_DEF = 7'o171;
  localparam logic [K-1:0] G1_DEF = 7'o133;

  typedef enum logic {RUN, FLUSH} enc_state_t;

  function automatic logic parity7(input logic [K-1:0] vec, input logic [K-1:0] poly);
    return ^(vec & poly);
  endfunction
endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - combinational encoder step: code pair and next shift-register state
module conv_enc_core
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         u,
  input  logic [M-1:0] sr,
  output logic [1:0]   pair,
  output logic [M-1:0] next_sr
);
  logic [K-1:0] v;

  // v = {u, sr[0], ..., sr[M-1]}: the oldest bit lands in v[0].
  always_comb begin
    v = '0;
    v[K-1] = u;
    for (int i = 0; i < M; i++) begin
      v[M-1-i] = sr[i];
    end
  end

  assign pair    = {parity7(v, G0), parity7(v, G1)};
  assign next_sr = {sr[M-2:0], u};
endmodule

// File: rtl/conv_encoder_k7.sv
// rtl/conv_encoder_k7.sv - rate-1/2 K=7 convolutional encoder with handshakes and optional zero tail
module conv_encoder_k7
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0      = G0_DEF,
  parameter logic [K-1:0] G1      = G1_DEF,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last
);
  enc_state_t   state;
  logic [M-1:0] sr;
  logic [M-1:0] next_sr;
  logic [2:0]   tcnt;
  logic [1:0]   pair;
  logic         advance;
  logic         u;

  assign advance  = !out_valid || out_ready;
  assign in_ready = (state == RUN) && advance;
  assign u        = (state == RUN) ? in_bit : 1'b0;

  conv_enc_core #(.G0(G0), .G1(G1)) u_core (
    .u       (u),
    .sr      (sr),
    .pair    (pair),
    .next_sr (next_sr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      sr        <= '0;
      tcnt      <= '0;
      out_valid <= 1'b0;
      out_pair  <= 2'b00;
      out_last  <= 1'b0;
    end else if (advance) begin
      case (state)
        RUN: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_pair  <= pair;
            // Without a tail the next frame must still start from state 0.
            if (in_last && !TAIL_EN) begin
              out_last <= 1'b1;
              sr       <= '0;
            end else begin
              out_last <= 1'b0;
              sr       <= next_sr;
            end
            if (in_last && TAIL_EN) begin
              state <= FLUSH;
              tcnt  <= '0;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          out_valid <= 1'b1;
          out_pair  <= pair;
          sr        <= next_sr;
          tcnt      <= tcnt + 3'd1;
          out_last  <= (tcnt == 3'(M-1));
          if (tcnt == 3'(M-1)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
